// File: rtl/ysyx_22050598_writeback_unit_if.sv
// Write-back unit bus: EXU handoff, LSU load return, RF write port and scoreboard.
// Optional bypass outputs are present when YSYX_22050598_WB_BYPASS_EN is defined.
interface ysyx_22050598_writeback_unit_if #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned AW   = 5
);
  logic            ex_valid;
  logic            ex_ready;
  logic [AW-1:0]   ex_rd;
  logic            ex_wen;
  logic            ex_is_load;
  logic [XLEN-1:0] ex_result;
  logic [2:0]      ex_funct3;
  logic [2:0]      ex_addr_lo;
  logic            lsu_rvalid;
  logic [XLEN-1:0] lsu_rdata;
  logic            rf_wen;
  logic [AW-1:0]   rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic [31:0]     pend_mask;
  logic            commit;
`ifdef YSYX_22050598_WB_BYPASS_EN
  logic            byp_valid;
  logic [AW-1:0]   byp_rd;
  logic [XLEN-1:0] byp_data;

  modport master (
    output ex_valid, ex_rd, ex_wen, ex_is_load, ex_result, ex_funct3, ex_addr_lo,
           lsu_rvalid, lsu_rdata,
    input  ex_ready, rf_wen, rf_waddr, rf_wdata, pend_mask, commit,
           byp_valid, byp_rd, byp_data
  );

  modport slave (
    input  ex_valid, ex_rd, ex_wen, ex_is_load, ex_result, ex_funct3, ex_addr_lo,
           lsu_rvalid, lsu_rdata,
    output ex_ready, rf_wen, rf_waddr, rf_wdata, pend_mask, commit,
           byp_valid, byp_rd, byp_data
  );
`else
  modport master (
    output ex_valid, ex_rd, ex_wen, ex_is_load, ex_result, ex_funct3, ex_addr_lo,
           lsu_rvalid, lsu_rdata,
    input  ex_ready, rf_wen, rf_waddr, rf_wdata, pend_mask, commit
  );

  modport slave (
    input  ex_valid, ex_rd, ex_wen, ex_is_load, ex_result, ex_funct3, ex_addr_lo,
           lsu_rvalid, lsu_rdata,
    output ex_ready, rf_wen, rf_waddr, rf_wdata, pend_mask, commit
  );
`endif
endinterface

// File: rtl/ysyx_22050598_writeback_unit.sv
// Write-back stage: sole writer of the 32x64 register file. Retires ALU results
// with latency 1, waits for LSU data on loads, extends it, and tracks pending
// destination registers for decode's RAW stall logic.
// Optional feature macro: YSYX_22050598_WB_BYPASS_EN (adds byp_* outputs and
// clears the pending bit in the same cycle the RF write is presented).
module ysyx_22050598_writeback_unit (
  input  logic                            clk,
  input  logic                            rst_n,
  ysyx_22050598_writeback_unit_if.slave   bus
);
  localparam int unsigned XLEN = 64;
  localparam int unsigned AW   = 5;
  localparam int unsigned NREG = 32;

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } state_t;

  state_t          state, state_nx;

  logic [AW-1:0]   ld_rd;
  logic            ld_wen;
  logic [2:0]      ld_funct3;
  logic [2:0]      ld_addr_lo;

  logic            rf_wen_q;
  logic [AW-1:0]   rf_waddr_q;
  logic [XLEN-1:0] rf_wdata_q;
  logic            commit_q;
  logic [NREG-1:0] pend_q;

  logic            accept_c;
  logic            retire_c;
  logic            wr_c;
  logic [AW-1:0]   wr_rd_c;
  logic [XLEN-1:0] wr_data_c;
  logic [XLEN-1:0] ld_shift_c;
  logic [XLEN-1:0] ld_ext_c;
  logic [NREG-1:0] set_c;
  logic [NREG-1:0] clr_c;

  assign bus.ex_ready  = (state == IDLE);
  assign bus.rf_wen    = rf_wen_q;
  assign bus.rf_waddr  = rf_waddr_q;
  assign bus.rf_wdata  = rf_wdata_q;
  assign bus.commit    = commit_q;
  assign bus.pend_mask = pend_q;
`ifdef YSYX_22050598_WB_BYPASS_EN
  assign bus.byp_valid = rf_wen_q;
  assign bus.byp_rd    = rf_waddr_q;
  assign bus.byp_data  = rf_wdata_q;
`endif

  // Select and sign/zero-extend the loaded field from the raw doubleword
  always_comb begin
    ld_shift_c = bus.lsu_rdata >> {ld_addr_lo, 3'b000};
    case (ld_funct3)
      3'b000:  ld_ext_c = {{(XLEN-8){ld_shift_c[7]}},   ld_shift_c[7:0]};
      3'b001:  ld_ext_c = {{(XLEN-16){ld_shift_c[15]}}, ld_shift_c[15:0]};
      3'b010:  ld_ext_c = {{(XLEN-32){ld_shift_c[31]}}, ld_shift_c[31:0]};
      3'b100:  ld_ext_c = {{(XLEN-8){1'b0}},            ld_shift_c[7:0]};
      3'b101:  ld_ext_c = {{(XLEN-16){1'b0}},           ld_shift_c[15:0]};
      3'b110:  ld_ext_c = {{(XLEN-32){1'b0}},           ld_shift_c[31:0]};
      default: ld_ext_c = ld_shift_c;
    endcase
  end

  // Next state, accept and retire decisions
  always_comb begin
    state_nx  = state;
    accept_c  = 1'b0;
    retire_c  = 1'b0;
    wr_c      = 1'b0;
    wr_rd_c   = bus.ex_rd;
    wr_data_c = bus.ex_result;
    case (state)
      IDLE: begin
        if (bus.ex_valid) begin
          accept_c = 1'b1;
          if (bus.ex_is_load) begin
            state_nx = WAIT_LOAD;
          end else begin
            retire_c = 1'b1;
            wr_c     = bus.ex_wen && (bus.ex_rd != '0);
          end
        end
      end
      WAIT_LOAD: begin
        if (bus.lsu_rvalid) begin
          retire_c  = 1'b1;
          wr_c      = ld_wen && (ld_rd != '0);
          wr_rd_c   = ld_rd;
          wr_data_c = ld_ext_c;
          state_nx  = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Scoreboard set/clear vectors
  always_comb begin
    set_c = '0;
    clr_c = '0;
`ifdef YSYX_22050598_WB_BYPASS_EN
    // A non-load's result is forwarded on the same edge it would be marked, so only loads mark
    if (accept_c && bus.ex_wen && bus.ex_is_load && (bus.ex_rd != '0)) begin
      set_c = NREG'(1) << bus.ex_rd;
    end
    if (wr_c) begin
      clr_c = NREG'(1) << wr_rd_c;
    end
`else
    if (accept_c && bus.ex_wen && (bus.ex_rd != '0)) begin
      set_c = NREG'(1) << bus.ex_rd;
    end
    // Clear only once the RF read port sees the new value
    if (rf_wen_q) begin
      clr_c = NREG'(1) << rf_waddr_q;
    end
`endif
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Latch load context at accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_rd      <= '0;
      ld_wen     <= 1'b0;
      ld_funct3  <= '0;
      ld_addr_lo <= '0;
    end else if (accept_c && bus.ex_is_load) begin
      ld_rd      <= bus.ex_rd;
      ld_wen     <= bus.ex_wen;
      ld_funct3  <= bus.ex_funct3;
      ld_addr_lo <= bus.ex_addr_lo;
    end
  end

  // Registered RF write port and commit pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      commit_q   <= 1'b0;
    end else begin
      rf_wen_q <= wr_c;
      commit_q <= retire_c;
      if (retire_c) begin
        rf_waddr_q <= wr_rd_c;
        rf_wdata_q <= wr_data_c;
      end
    end
  end

  // Pending-write mask; a new set beats a clear of the same bit, x0 never pending
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= ((pend_q & ~clr_c) | set_c) & ~NREG'(1);
    end
  end

endmodule

// File: tb/tb_ysyx_22050598_writeback_unit.sv
// Self-checking bench for the write-back unit: directed vectors with literal
// expectations plus an instruction-level reference model checked every cycle.
module tb_ysyx_22050598_writeback_unit;
  localparam logic [63:0] RAW = 64'h8877_6655_4433_2281;

  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   tot_cnt;

  ysyx_22050598_writeback_unit_if b ();

  ysyx_22050598_writeback_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
  endtask

  // Load extraction from the rules: shift to the byte offset, keep the access size, extend
  function automatic logic [63:0] ext_model(input logic [63:0] raw, input logic [2:0] f3,
                                            input logic [2:0] lo);
    logic [63:0] d;
    logic [63:0] keep_mask;
    int          nbits;
    d = raw >> (int'(lo) * 8);
    case (f3[1:0])
      2'd0:    nbits = 8;
      2'd1:    nbits = 16;
      2'd2:    nbits = 32;
      default: nbits = 64;
    endcase
    if (nbits == 64) return d;
    keep_mask = (64'd1 << nbits) - 64'd1;
    d = d & keep_mask;
    if (!f3[2] && d[nbits-1]) d = d | ~keep_mask;
    return d;
  endfunction

  // Reference model: per-register sequence numbers of last accepted vs last visible write
  int          seq;
  int          acc_seq [32];
  int          vis_seq [32];
  logic        m_busy;
  logic        m_wen;
  logic        m_commit;
  logic [4:0]  m_waddr;
  logic [63:0] m_wdata;
  int          m_wseq;
  logic [4:0]  l_rd;
  logic        l_wen;
  logic [2:0]  l_f3;
  logic [2:0]  l_lo;
  int          l_seq;
  logic        pv_wen;
  logic [4:0]  pv_waddr;
  int          pv_seq;
  logic [31:0] e_pend;

  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        seq = 0; m_busy = 0; m_wen = 0; m_commit = 0; m_waddr = '0; m_wdata = '0; m_wseq = 0;
        for (int r = 0; r < 32; r++) begin acc_seq[r] = 0; vis_seq[r] = 0; end
      end else begin
        pv_wen = m_wen; pv_waddr = m_waddr; pv_seq = m_wseq;
        m_wen = 0; m_commit = 0;
        if (!m_busy && b.ex_valid) begin
          seq++;
          if (b.ex_wen && b.ex_rd != 0) acc_seq[b.ex_rd] = seq;
          if (!b.ex_is_load) begin
            m_commit = 1; m_wen = b.ex_wen && b.ex_rd != 0;
            m_waddr = b.ex_rd; m_wdata = b.ex_result; m_wseq = seq;
          end else begin
            m_busy = 1; l_rd = b.ex_rd; l_wen = b.ex_wen;
            l_f3 = b.ex_funct3; l_lo = b.ex_addr_lo; l_seq = seq;
          end
        end else if (m_busy && b.lsu_rvalid) begin
          m_busy = 0; m_commit = 1; m_wen = l_wen && l_rd != 0;
          m_waddr = l_rd; m_wdata = ext_model(b.lsu_rdata, l_f3, l_lo); m_wseq = l_seq;
        end
`ifdef YSYX_22050598_WB_BYPASS_EN
        if (m_wen) vis_seq[m_waddr] = m_wseq;
`else
        if (pv_wen) vis_seq[pv_waddr] = pv_seq;
`endif
      end
    end
  end

  // Compare DUT against the model every cycle out of reset
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int r = 0; r < 32; r++) e_pend[r] = (acc_seq[r] > vis_seq[r]);
        chk("m_ex_ready", 64'(b.ex_ready), 64'(!m_busy));
        chk("m_rf_wen", 64'(b.rf_wen), 64'(m_wen));
        chk("m_commit", 64'(b.commit), 64'(m_commit));
        chk("m_pend_mask", 64'(b.pend_mask), 64'(e_pend));
        if (m_commit) begin
          chk("m_rf_waddr", 64'(b.rf_waddr), 64'(m_waddr));
          chk("m_rf_wdata", b.rf_wdata, m_wdata);
        end
`ifdef YSYX_22050598_WB_BYPASS_EN
        chk("m_byp_valid", 64'(b.byp_valid), 64'(m_wen));
        if (m_wen) begin
          chk("m_byp_rd", 64'(b.byp_rd), 64'(m_waddr));
          chk("m_byp_data", b.byp_data, m_wdata);
        end
`endif
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd, input logic wen, input logic ld,
                       input logic [63:0] res, input logic [2:0] f3, input logic [2:0] lo);
    b.ex_valid = 1; b.ex_rd = rd; b.ex_wen = wen; b.ex_is_load = ld;
    b.ex_result = res; b.ex_funct3 = f3; b.ex_addr_lo = lo;
  endtask

  task automatic run_load(input string name, input logic [2:0] f3, input logic [2:0] lo,
                          input logic [63:0] exp);
    issue(5'd10, 1, 1, 64'h0, f3, lo);
    tick;
    b.ex_valid = 0;
    chk({name, "_stall"}, 64'(b.ex_ready), 64'd0);
    b.lsu_rdata = RAW; b.lsu_rvalid = 1;
    tick;
    b.lsu_rvalid = 0;
    chk({name, "_wen"}, 64'(b.rf_wen), 64'd1);
    chk({name, "_data"}, b.rf_wdata, exp);
  endtask

  initial begin
    clk = 0; rst_n = 0; pass_cnt = 0; tot_cnt = 0;
    b.ex_valid = 0; b.ex_rd = '0; b.ex_wen = 0; b.ex_is_load = 0; b.ex_result = '0;
    b.ex_funct3 = '0; b.ex_addr_lo = '0; b.lsu_rvalid = 0; b.lsu_rdata = '0;

    // Model pins
    chk("pin_lb", ext_model(RAW, 3'b000, 3'd0), 64'hFFFF_FFFF_FFFF_FF81);
    chk("pin_lw4", ext_model(RAW, 3'b010, 3'd4), 64'hFFFF_FFFF_8877_6655);
    chk("pin_lhu2", ext_model(RAW, 3'b101, 3'd2), 64'h0000_0000_0000_4433);

    // Reset values
    tick; tick;
    chk("rst_wen", 64'(b.rf_wen), 64'd0);
    chk("rst_waddr", 64'(b.rf_waddr), 64'd0);
    chk("rst_wdata", b.rf_wdata, 64'd0);
    chk("rst_pend", 64'(b.pend_mask), 64'd0);
    chk("rst_commit", 64'(b.commit), 64'd0);
    rst_n = 1;
    tick;
    chk("rst_ready", 64'(b.ex_ready), 64'd1);

    // ALU stream x5, x6, x0
    issue(5'd5, 1, 0, 64'h11, 3'b0, 3'd0); tick;
    chk("alu5_wen", 64'(b.rf_wen), 64'd1);
    chk("alu5_addr", 64'(b.rf_waddr), 64'd5);
    chk("alu5_data", b.rf_wdata, 64'h11);
    issue(5'd6, 1, 0, 64'h22, 3'b0, 3'd0); tick;
    chk("alu6_wen", 64'(b.rf_wen), 64'd1);
    chk("alu6_data", b.rf_wdata, 64'h22);
    issue(5'd0, 1, 0, 64'h33, 3'b0, 3'd0); tick;
    b.ex_valid = 0;
    chk("alu0_wen", 64'(b.rf_wen), 64'd0);
    chk("alu0_commit", 64'(b.commit), 64'd1);
    tick;
    chk("alu_idle_commit", 64'(b.commit), 64'd0);
    tick;

    // Load extraction vectors
    run_load("lb", 3'b000, 3'd0, 64'hFFFF_FFFF_FFFF_FF81);
    run_load("lbu", 3'b100, 3'd0, 64'h0000_0000_0000_0081);
    run_load("lw4", 3'b010, 3'd4, 64'hFFFF_FFFF_8877_6655);
    run_load("lwu4", 3'b110, 3'd4, 64'h0000_0000_8877_6655);
    run_load("lh6", 3'b001, 3'd6, 64'hFFFF_FFFF_FFFF_8877);
    run_load("ld", 3'b011, 3'd0, RAW);
    run_load("f111", 3'b111, 3'd0, RAW);
    tick; tick;

    // Load stall on x7
    issue(5'd7, 1, 1, 64'h0, 3'b011, 3'd0); tick;
    b.ex_valid = 0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_ready", 64'(b.ex_ready), 64'd0);
      chk("stall_pend7", 64'(b.pend_mask[7]), 64'd1);
      chk("stall_wen", 64'(b.rf_wen), 64'd0);
      tick;
    end
    b.lsu_rdata = 64'h1234; b.lsu_rvalid = 1; tick;
    b.lsu_rvalid = 0;
    chk("stall_wr_wen", 64'(b.rf_wen), 64'd1);
    chk("stall_wr_addr", 64'(b.rf_waddr), 64'd7);
`ifdef YSYX_22050598_WB_BYPASS_EN
    chk("stall_wr_pend7", 64'(b.pend_mask[7]), 64'd0);
`else
    chk("stall_wr_pend7", 64'(b.pend_mask[7]), 64'd1);
`endif
    tick;
    chk("stall_after_pend7", 64'(b.pend_mask[7]), 64'd0);
    tick;

    // Scoreboard overlap on x9
    issue(5'd9, 1, 0, 64'h99, 3'b0, 3'd0); tick;
`ifdef YSYX_22050598_WB_BYPASS_EN
    chk("ovl_alu_pend9", 64'(b.pend_mask[9]), 64'd0);
`else
    chk("ovl_alu_pend9", 64'(b.pend_mask[9]), 64'd1);
`endif
    issue(5'd9, 1, 1, 64'h0, 3'b011, 3'd0); tick;
    b.ex_valid = 0;
    chk("ovl_ld_pend9", 64'(b.pend_mask[9]), 64'd1);
    tick;
    chk("ovl_wait_pend9", 64'(b.pend_mask[9]), 64'd1);
    b.lsu_rdata = RAW; b.lsu_rvalid = 1; tick;
    b.lsu_rvalid = 0;
    chk("ovl_wr_data", b.rf_wdata, RAW);
`ifdef YSYX_22050598_WB_BYPASS_EN
    chk("ovl_wr_pend9", 64'(b.pend_mask[9]), 64'd0);
`else
    chk("ovl_wr_pend9", 64'(b.pend_mask[9]), 64'd1);
`endif
    tick;
    chk("ovl_done_pend9", 64'(b.pend_mask[9]), 64'd0);

    // ALU x3 = 0xABCD, bypass visibility
    issue(5'd3, 1, 0, 64'hABCD, 3'b0, 3'd0); tick;
    b.ex_valid = 0;
`ifdef YSYX_22050598_WB_BYPASS_EN
    chk("byp_valid", 64'(b.byp_valid), 64'd1);
    chk("byp_rd", 64'(b.byp_rd), 64'd3);
    chk("byp_data", b.byp_data, 64'hABCD);
    chk("byp_pend3", 64'(b.pend_mask[3]), 64'd0);
`else
    chk("nobyp_pend3", 64'(b.pend_mask[3]), 64'd1);
`endif
    tick;
    chk("x3_after_pend3", 64'(b.pend_mask[3]), 64'd0);

    // Reset in WAIT_LOAD drops the load; stale response afterwards is ignored
    issue(5'd12, 1, 1, 64'h0, 3'b011, 3'd0); tick;
    b.ex_valid = 0;
    chk("rmid_pend12", 64'(b.pend_mask[12]), 64'd1);
    rst_n = 0;
    #1;
    chk("rmid_pend", 64'(b.pend_mask), 64'd0);
    chk("rmid_wen", 64'(b.rf_wen), 64'd0);
    tick; tick;
    rst_n = 1;
    b.lsu_rdata = RAW; b.lsu_rvalid = 1;
    chk("rmid_ready", 64'(b.ex_ready), 64'd1);
    tick;
    b.lsu_rvalid = 0;
    chk("stale_wen", 64'(b.rf_wen), 64'd0);
    chk("stale_commit", 64'(b.commit), 64'd0);
    tick; tick;

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
